// File: rtl/rlen_partition.sv
// rlen_partition: DMA read job splitter and read-completion tracker.
// Cuts a byte-addressed read job into 16-beat-aligned INCR AR bursts,
// limits the number of bursts in flight, and pulses dmar_done once every
// issued burst has returned its last R beat.
module rlen_partition #(
   parameter int AXI_DW     = 128,
   parameter int AXI_AW     = 32,
   parameter int AXI_IW     = 8,
   parameter int AXI_LW     = 8,
   parameter int AXI_SW     = 3,
   parameter int AXI_BURSTW = 2,
   parameter int AMI_OD     = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cfg_dmar_valid,
   output logic                  cfg_dmar_ready,
   input  logic [31:0]           cfg_dmar_sa,
   input  logic [31:0]           cfg_dmar_len,
   output logic [AXI_IW-1:0]     arid,
   output logic [AXI_AW-1:0]     araddr,
   output logic [AXI_LW-1:0]     arlen,
   output logic [AXI_SW-1:0]     arsize,
   output logic [AXI_BURSTW-1:0] arburst,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic                  rvalid,
   input  logic                  rready,
   input  logic                  rlast,
   output logic                  dmar_done
);

   localparam int AXI_BYTES = AXI_DW / 8;
   localparam int L         = $clog2(AXI_BYTES);
   localparam int BL        = 16;
   localparam int B         = $clog2(BL) + L;
   localparam int OW        = $clog2(AMI_OD + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADDR  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [31:L]   sa_beat;
   logic [31:L]   len_beat;
   logic [31:L]   len_beat_in;
   logic [31:L]   bnd_m1;
   logic [31:L]   len_m1;
   logic [31:L]   burst_m1;
   logic [31:L]   burst;
   logic [OW-1:0] outstanding;
   logic [OW-1:0] outstanding_nxt;
   logic          cfg_hs;
   logic          ar_hs;
   logic          r_hs;
   logic          done_set;
   logic          unused_bits;

   // Sub-beat address/length bits carry no meaning: only whole beats move.
   assign unused_bits = ^{cfg_dmar_sa[L-1:0], cfg_dmar_len[L-1:0]};

   assign len_beat_in = cfg_dmar_len[31:L];
   assign cfg_dmar_ready = (state == IDLE);
   // outstanding only rises on an AR handshake, so while a request waits the
   // gate can only stay open: arvalid/araddr/arlen hold until arready.
   assign arvalid = (state == ADDR) && (outstanding < OW'(AMI_OD));
   assign cfg_hs  = cfg_dmar_valid & cfg_dmar_ready;
   assign ar_hs   = arvalid & arready;
   // A stray last beat with nothing in flight is dropped (count saturates at 0).
   assign r_hs    = rvalid & rready & rlast & (outstanding != '0);

   // Beats left before the next 16-beat boundary vs. beats left in the job.
   assign bnd_m1   = {{(32 - B){1'b0}}, ~sa_beat[B-1:L]};
   assign len_m1   = len_beat - (32 - L)'(1);
   assign burst_m1 = (bnd_m1 < len_m1) ? bnd_m1 : len_m1;
   assign burst    = burst_m1 + (32 - L)'(1);

   assign arid    = AXI_IW'(1);
   assign arsize  = AXI_SW'(L);
   assign arburst = AXI_BURSTW'(1);
   assign araddr  = {sa_beat[AXI_AW-1:L], {L{1'b0}}};
   assign arlen   = (state == ADDR) ? AXI_LW'(burst_m1) : '0;

   // In-flight burst count: +1 per AR handshake, -1 per accepted last beat.
   always_comb begin
      outstanding_nxt = outstanding;
      case ({ar_hs, r_hs})
         2'b10:   outstanding_nxt = outstanding + OW'(1);
         2'b01:   outstanding_nxt = outstanding - OW'(1);
         default: outstanding_nxt = outstanding;
      endcase
   end

   // Next-state logic and the completion-pulse request.
   always_comb begin
      state_nxt = state;
      done_set  = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_hs) begin
               if (len_beat_in != '0) begin
                  state_nxt = ADDR;
               end else begin
                  done_set = 1'b1;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         ADDR: begin
            if (ar_hs && (len_beat == burst)) begin
               state_nxt = DRAIN;
            end else begin
               state_nxt = ADDR;
            end
         end
         DRAIN: begin
            if (outstanding_nxt == '0) begin
               state_nxt = IDLE;
               done_set  = 1'b1;
            end else begin
               state_nxt = DRAIN;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, in-flight count and the registered done pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         outstanding <= '0;
         dmar_done   <= 1'b0;
      end else begin
         state       <= state_nxt;
         outstanding <= outstanding_nxt;
         dmar_done   <= done_set;
      end
   end

   // Job cursor: load on acceptance, advance by one burst per AR handshake.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sa_beat  <= '0;
         len_beat <= '0;
      end else if (cfg_hs && (len_beat_in != '0)) begin
         sa_beat  <= cfg_dmar_sa[31:L];
         len_beat <= len_beat_in;
      end else if (ar_hs) begin
         sa_beat  <= sa_beat + burst;
         len_beat <= len_beat - burst;
      end else begin
         sa_beat  <= sa_beat;
         len_beat <= len_beat;
      end
   end

endmodule

// File: tb/tb_rlen_partition.sv
// Directed bench for rlen_partition (AXI_DW=128, AMI_OD=4).
module tb_rlen_partition;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cfg_dmar_valid = 1'b0;
   logic        cfg_dmar_ready;
   logic [31:0] cfg_dmar_sa = 32'h0;
   logic [31:0] cfg_dmar_len = 32'h0;
   logic [7:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready = 1'b0;
   logic        rvalid = 1'b0;
   logic        rready = 1'b0;
   logic        rlast = 1'b0;
   logic        dmar_done;

   int n_checks = 0;
   int n_fail = 0;

   rlen_partition dut (
      .clk(clk), .reset_n(reset_n),
      .cfg_dmar_valid(cfg_dmar_valid), .cfg_dmar_ready(cfg_dmar_ready),
      .cfg_dmar_sa(cfg_dmar_sa), .cfg_dmar_len(cfg_dmar_len),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rvalid(rvalid), .rready(rready), .rlast(rlast), .dmar_done(dmar_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]       sa;
      logic [31:0]       len;
      int                n;
      logic [3:0][31:0]  addr;
      logic [3:0][7:0]   alen;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input logic [31:0] sa, input logic [31:0] len, input int n,
                          input logic [31:0] a0, input logic [7:0] l0,
                          input logic [31:0] a1, input logic [7:0] l1,
                          input logic [31:0] a2, input logic [7:0] l2);
      vec_t v;
      v.sa = sa; v.len = len; v.n = n;
      v.addr = '0; v.alen = '0;
      v.addr[0] = a0; v.alen[0] = l0;
      v.addr[1] = a1; v.alen[1] = l1;
      v.addr[2] = a2; v.alen[2] = l2;
      tbl.push_back(v);
   endtask

   task automatic cfg_job(input logic [31:0] sa, input logic [31:0] len);
      cfg_dmar_sa = sa;
      cfg_dmar_len = len;
      cfg_dmar_valid = 1'b1;
      tick();
      cfg_dmar_valid = 1'b0;
   endtask

   task automatic pulse_rlast();
      rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
      tick();
      rvalid = 1'b0; rlast = 1'b0;
   endtask

   // Run one table entry: collect ARs with arready high, return all beats,
   // then check the done pulse timing.
   task automatic run_entry(input int i);
      int n;
      int early;
      logic [3:0][31:0] ga;
      logic [3:0][7:0]  gl;
      n = 0; early = 0; ga = '0; gl = '0;
      arready = 1'b1;
      cfg_job(tbl[i].sa, tbl[i].len);
      chk($sformatf("v%0d_first_arvalid", i), {31'h0, arvalid}, 32'h1);
      for (int c = 0; c < 40; c++) begin
         if (arvalid) begin
            if (n < 4) begin
               ga[n] = araddr;
               gl[n] = arlen;
            end
            n++;
         end else if (n > 0) begin
            break;
         end
         tick();
      end
      chk($sformatf("v%0d_ar_count", i), n, tbl[i].n);
      for (int b = 0; b < tbl[i].n && b < 4; b++) begin
         chk($sformatf("v%0d_araddr%0d", i, b), ga[b], tbl[i].addr[b]);
         chk($sformatf("v%0d_arlen%0d", i, b), {24'h0, gl[b]}, {24'h0, tbl[i].alen[b]});
      end
      for (int b = 0; b < tbl[i].n; b++) begin
         for (int k = 0; k <= int'(tbl[i].alen[b]); k++) begin
            rvalid = 1'b1; rready = 1'b1;
            rlast = (k == int'(tbl[i].alen[b]));
            if (dmar_done) early++;
            tick();
         end
      end
      rvalid = 1'b0; rlast = 1'b0;
      chk($sformatf("v%0d_no_early_done", i), early, 0);
      chk($sformatf("v%0d_done_pulse", i), {31'h0, dmar_done}, 32'h1);
      chk($sformatf("v%0d_ready_back", i), {31'h0, cfg_dmar_ready}, 32'h1);
      tick();
      chk($sformatf("v%0d_done_one_cycle", i), {31'h0, dmar_done}, 32'h0);
   endtask

   initial begin
      int n;
      int bad;
      int seen;
      logic [7:0][31:0] addrs;

      add_vec(32'h0000_0000, 32'h100, 1, 32'h0000_0000, 8'd15, 32'h0, 8'd0, 32'h0, 8'd0);
      add_vec(32'h0000_1230, 32'h200, 3, 32'h0000_1230, 8'd12, 32'h0000_1300, 8'd15, 32'h0000_1400, 8'd2);
      add_vec(32'hFFFF_FFF0, 32'h020, 2, 32'hFFFF_FFF0, 8'd0, 32'h0000_0000, 8'd0, 32'h0, 8'd0);
      add_vec(32'h0000_0040, 32'h050, 1, 32'h0000_0040, 8'd4, 32'h0, 8'd0, 32'h0, 8'd0);
      add_vec(32'h0000_0105, 32'h03F, 1, 32'h0000_0100, 8'd2, 32'h0, 8'd0, 32'h0, 8'd0);

      // Reset state.
      tick(); tick();
      chk("rst_arvalid", {31'h0, arvalid}, 32'h0);
      chk("rst_ready", {31'h0, cfg_dmar_ready}, 32'h1);
      chk("rst_done", {31'h0, dmar_done}, 32'h0);
      chk("rst_araddr", araddr, 32'h0);
      reset_n = 1'b1;
      tick();
      chk("const_arid", {24'h0, arid}, 32'h1);
      chk("const_arsize", {29'h0, arsize}, 32'h4);
      chk("const_arburst", {30'h0, arburst}, 32'h1);

      // Table-driven jobs.
      for (int i = 0; i < tbl.size(); i++) begin
         run_entry(i);
      end

      // Zero-beat job: accepted, no AR, done the next cycle.
      cfg_job(32'h0000_1000, 32'h8);
      chk("zl_arvalid", {31'h0, arvalid}, 32'h0);
      chk("zl_done", {31'h0, dmar_done}, 32'h1);
      chk("zl_ready", {31'h0, cfg_dmar_ready}, 32'h1);
      tick();
      chk("zl_done_clear", {31'h0, dmar_done}, 32'h0);

      // Outstanding cap with no returns.
      arready = 1'b1; n = 0; addrs = '0;
      cfg_job(32'h0, 32'h1000);
      for (int c = 0; c < 12; c++) begin
         if (arvalid) begin
            if (n < 8) addrs[n] = araddr;
            n++;
         end
         tick();
      end
      chk("od_count", n, 4);
      for (int b = 0; b < 4; b++) begin
         chk($sformatf("od_addr%0d", b), addrs[b], 32'(b) * 32'h100);
      end
      chk("od_arvalid_low", {31'h0, arvalid}, 32'h0);
      pulse_rlast();
      chk("od_reopen", {31'h0, arvalid}, 32'h1);
      chk("od_reopen_addr", araddr, 32'h400);
      tick();
      chk("od_one_more_only", {31'h0, arvalid}, 32'h0);
      pulse_rlast();
      rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
      tick();
      rvalid = 1'b0; rlast = 1'b0;
      chk("sim_arvalid", {31'h0, arvalid}, 32'h1);
      chk("sim_addr", araddr, 32'h600);
      tick();
      chk("sim_count_const", {31'h0, arvalid}, 32'h0);

      // AR stall: request holds steady, even across an rlast.
      arready = 1'b0;
      pulse_rlast();
      chk("stall_addr", araddr, 32'h700);
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         if (!(arvalid === 1'b1 && araddr === 32'h700 && arlen === 8'd15)) bad++;
         if (c == 4) begin
            pulse_rlast();
         end else begin
            tick();
         end
      end
      chk("stall_hold", bad, 0);
      arready = 1'b1; rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
      seen = 0;
      for (int c = 0; c < 200 && seen == 0; c++) begin
         tick();
         if (dmar_done) seen = 1;
      end
      chk("big_job_done", seen, 1);
      tick();
      chk("big_job_done_one_cycle", {31'h0, dmar_done}, 32'h0);
      rvalid = 1'b0; rlast = 1'b0;
      tick();

      // Reset during DRAIN with two bursts outstanding.
      arready = 1'b1;
      cfg_job(32'h0, 32'h200);
      tick(); tick(); tick();
      chk("drain_ready_low", {31'h0, cfg_dmar_ready}, 32'h0);
      chk("drain_arvalid_low", {31'h0, arvalid}, 32'h0);
      reset_n = 1'b0;
      #1;
      chk("mrst_arvalid", {31'h0, arvalid}, 32'h0);
      chk("mrst_ready", {31'h0, cfg_dmar_ready}, 32'h1);
      chk("mrst_araddr", araddr, 32'h0);
      tick();
      reset_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         if (dmar_done) seen = 1;
         tick();
      end
      chk("mrst_no_done", seen, 0);
      run_entry(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
